uart_rx_buffered: RTL and testbench

On-chip UART receive path between the board serial pin `serial_in` and the CPU's memory-mapped UART receive registers. It synchronizes and oversamples the asynchronous 8N1 line and deframes bytes LSB-first. Received bytes go into a small FIFO, which the CPU drains through a ready/valid port. Framing errors and FIFO overrun are reported as sticky flags.

---
 rtl/uart_rx_buffered.sv | 156 +++++++++++++++
 tb/tb_uart_rx_buffered.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling deframer, and a small
// receive FIFO drained through a ready/valid port, with sticky framing/overrun flags.
module uart_rx_buffered #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    input  logic       clear_errors
);

    localparam int unsigned SymbolEdgeTime = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned SampleTime     = SymbolEdgeTime / 2;
    localparam int unsigned CntW           = $clog2(SymbolEdgeTime) + 1;
    localparam int unsigned PtrW           = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);
    localparam logic [CntW-1:0] SymbolLast = CntW'(SymbolEdgeTime - 1);
    localparam logic [PtrW:0]   FullCount  = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            sync_q;
    logic            rx_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [PtrW:0]   count_d;
    logic            framing_q;
    logic            overrun_q;

    logic stop_sample;
    logic push;
    logic frame_err_evt;
    logic pop;
    logic full;
    logic push_acc;
    logic overrun_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b1;
            rx_q   <= 1'b1;
        end else begin
            sync_q <= serial_in;
            rx_q   <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_q) state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == SampleLast) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == SymbolLast) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    // Back to idle on the stop sample itself so back-to-back frames re-sync at once.
                    if (cnt_q == SymbolLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stop_sample   = (state_q == StStop) && (cnt_q == SymbolLast);
        push          = stop_sample && rx_q;
        frame_err_evt = stop_sample && !rx_q;
        data_out_valid = (count_q != '0);
        pop           = data_out_valid && data_out_ready;
        full          = (count_q == FullCount);
        push_acc      = push && (!full || pop);
        overrun_evt   = push && full && !pop;
        count_d       = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_acc) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // An error event in the same cycle as clear_errors leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            framing_q <= frame_err_evt || (framing_q && !clear_errors);
            overrun_q <= overrun_evt || (overrun_q && !clear_errors);
        end
    end

    assign data_out      = mem_q[rd_ptr_q];
    assign framing_error = framing_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: 5-cycle bit period, host task drives 8N1 frames
// and each scenario task checks flags and FIFO output against hand-derived values.
module tb_uart_rx_buffered;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic       framing_error;
    logic       overrun;
    logic       clear_errors = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_buffered #(
        .CLOCK_FREQ(50_000_000),
        .BAUD_RATE (10_000_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .clear_errors  (clear_errors)
    );

    always #10 clk = ~clk;

    // Returns just after the stop-sample edge; optionally raises ready for that edge only.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop);
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 serial_in = b[i];
            repeat (5) @(posedge clk);
        end
        #1 serial_in = stop_bit;
        repeat (4) @(posedge clk);
        if (pop_at_stop) #1 data_out_ready = 1'b1;
        @(posedge clk);
        if (pop_at_stop) #1 data_out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        #1 serial_in = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear_errors = 1'b1;
        @(negedge clk) clear_errors = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        serial_in = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (data_out_valid !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0
            || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset: valid=%b fe=%b ov=%b data=%h expected 0 0 0 00",
                     data_out_valid, framing_error, overrun, data_out);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_out_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_idle: valid high in %0d cycles, expected 0", bad);
        end
    endtask

    task automatic test_single();
        data_out_ready = 1'b1;
        send_byte(8'h78, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (data_out_valid !== 1'b1 || data_out !== 8'h78) begin
            n_err++;
            $display("FAIL single: valid=%b data=%h expected 1 78", data_out_valid, data_out);
        end
        @(negedge clk);
        n_vec++;
        if (data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_one_cycle: valid=%b expected 0", data_out_valid);
        end
        idle(10);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h78, 8'h79, 8'h7a, 8'h0d};
        data_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(exp[i], 1'b1, 1'b0);
        idle(10);
        @(negedge clk);
        data_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (data_out_valid !== 1'b1 || data_out !== exp[i]) begin
                n_err++;
                $display("FAIL buffer[%0d]: valid=%b data=%h expected 1 %h",
                         i, data_out_valid, data_out, exp[i]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (data_out_valid !== 1'b0 || overrun !== 1'b0 || framing_error !== 1'b0) begin
            n_err++;
            $display("FAIL buffer_end: valid=%b ov=%b fe=%b expected 0 0 0",
                     data_out_valid, overrun, framing_error);
        end
        data_out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] exp [5];
        logic [7:0] exp2 [4];
        exp  = '{8'h31, 8'h35, 8'h31, 8'h3e, 8'h20};
        exp2 = '{8'h02, 8'h03, 8'h04, 8'h05};
        data_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(exp[i], 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (overrun !== 1'b1 || framing_error !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_set: ov=%b fe=%b expected 1 0", overrun, framing_error);
        end
        data_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (data_out_valid !== 1'b1 || data_out !== exp[i]) begin
                n_err++;
                $display("FAIL overrun_drain[%0d]: valid=%b data=%h expected 1 %h",
                         i, data_out_valid, data_out, exp[i]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_empty: valid=%b expected 0", data_out_valid);
        end
        data_out_ready = 1'b0;
        pulse_clear();
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: ov=%b expected 0", overrun);
        end
        // Fill, then land a pop on the same edge as the fifth push.
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b0);
        send_byte(8'h05, 1'b1, 1'b1);
        @(negedge clk);
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL push_pop_full: ov=%b expected 0", overrun);
        end
        data_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (data_out_valid !== 1'b1 || data_out !== exp2[i]) begin
                n_err++;
                $display("FAIL push_pop_drain[%0d]: valid=%b data=%h expected 1 %h",
                         i, data_out_valid, data_out, exp2[i]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL push_pop_empty: valid=%b expected 0", data_out_valid);
        end
        data_out_ready = 1'b0;
    endtask

    task automatic test_framing_glitch();
        data_out_ready = 1'b0;
        send_byte(8'h55, 1'b0, 1'b0);
        idle(20);
        @(negedge clk);
        n_vec++;
        if (framing_error !== 1'b1 || data_out_valid !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL framing: fe=%b valid=%b ov=%b expected 1 0 0",
                     framing_error, data_out_valid, overrun);
        end
        pulse_clear();
        n_vec++;
        if (framing_error !== 1'b0) begin
            n_err++;
            $display("FAIL framing_clear: fe=%b expected 0", framing_error);
        end
        @(posedge clk);
        #1 serial_in = 1'b0;
        @(posedge clk);
        #1 serial_in = 1'b1;
        idle(20);
        @(negedge clk);
        n_vec++;
        if (framing_error !== 1'b0 || data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL glitch: fe=%b valid=%b expected 0 0", framing_error, data_out_valid);
        end
        data_out_ready = 1'b1;
        send_byte(8'ha5, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (data_out_valid !== 1'b1 || data_out !== 8'ha5 || framing_error !== 1'b0) begin
            n_err++;
            $display("FAIL after_glitch: valid=%b data=%h fe=%b expected 1 a5 0",
                     data_out_valid, data_out, framing_error);
        end
        idle(10);
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h3c;
        data_out_ready = 1'b0;
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 serial_in = b[i];
            repeat (5) @(posedge clk);
        end
        #1 serial_in = b[4];
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(60);
        @(negedge clk);
        n_vec++;
        if (data_out_valid !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_frame: valid=%b fe=%b ov=%b expected 0 0 0",
                     data_out_valid, framing_error, overrun);
        end
        data_out_ready = 1'b1;
        send_byte(8'hc3, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (data_out_valid !== 1'b1 || data_out !== 8'hc3) begin
            n_err++;
            $display("FAIL after_reset: valid=%b data=%h expected 1 c3", data_out_valid, data_out);
        end
        idle(10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_framing_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
